// File: rtl/adc_sample_buffer_slave.sv
// ADC capture command responder: byte-lane sample RAM with registered read, fill level and sticky error flags.
// Optional running checksum of full-word writes is enabled by defining ADC_BUF_CHECKSUM_EN.
module adc_sample_buffer_slave #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fifo_init,
  input  logic              fifo_write,
  input  logic              fifo_read,
  input  logic              sdram_op_rw,
  input  logic [1:0]        sdram_byte_sel,
  input  logic [31:0]       sdram_addr,
  input  logic [15:0]       sdram_data,
  output logic [15:0]       rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow,
  output logic              addr_err,
  output logic              cmd_err,
  output logic [15:0]       checksum
);

  localparam logic [ADDR_W:0] LEVEL_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LEVEL_ONE = (ADDR_W + 1)'(1);

  logic [ADDR_W-1:0] idx;
  logic              addr_ok;
  logic              wr_cmd;
  logic              rd_cmd;
  logic              cmd_bad;
  logic              wr_accept;
  logic              rd_accept;
  logic [7:0]        lane_rd [2];
  logic [15:0]       rd_word;

  logic [15:0]       rd_data_reg;
  logic              rd_valid_reg;
  logic [ADDR_W:0]   level_reg;
  logic              overflow_reg;
  logic              underflow_reg;
  logic              addr_err_reg;
  logic              cmd_err_reg;

  assign idx     = sdram_addr[ADDR_W-1:0];
  assign addr_ok = (sdram_addr < 32'(DEPTH));

  // fifo_init masks every strobe in the same cycle; dual strobes and op/strobe mismatches are protocol errors.
  assign wr_cmd  = !fifo_init && fifo_write && !fifo_read && sdram_op_rw;
  assign rd_cmd  = !fifo_init && fifo_read && !fifo_write && !sdram_op_rw;
  assign cmd_bad = !fifo_init && (fifo_write || fifo_read) && !wr_cmd && !rd_cmd;

  assign full  = (level_reg == LEVEL_MAX);
  assign empty = (level_reg == '0);

  assign wr_accept = wr_cmd && addr_ok && !full;
  assign rd_accept = rd_cmd && addr_ok && !empty;

  // One RAM per byte lane so byte enables map onto independent write ports.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (wr_accept && sdram_byte_sel[gi]) begin
          lane_mem[idx] <= sdram_data[gi*8 +: 8];
        end
      end

      assign lane_rd[gi] = lane_mem[idx];
    end
  endgenerate

  assign rd_word = {lane_rd[1], lane_rd[0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_reg   <= '0;
      rd_valid_reg  <= 1'b0;
      level_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      addr_err_reg  <= 1'b0;
      cmd_err_reg   <= 1'b0;
    end else begin
      rd_valid_reg <= rd_cmd;
      // Out-of-range reads still answer, with zero data, so the master never stalls.
      if (rd_cmd) begin
        rd_data_reg <= addr_ok ? rd_word : 16'h0000;
      end
      if (fifo_init) begin
        level_reg     <= '0;
        overflow_reg  <= 1'b0;
        underflow_reg <= 1'b0;
        addr_err_reg  <= 1'b0;
        cmd_err_reg   <= 1'b0;
      end else begin
        if (wr_accept) begin
          level_reg <= level_reg + LEVEL_ONE;
        end else if (rd_accept) begin
          level_reg <= level_reg - LEVEL_ONE;
        end
        if ((wr_cmd || rd_cmd) && !addr_ok) begin
          addr_err_reg <= 1'b1;
        end
        if (wr_cmd && addr_ok && full) begin
          overflow_reg <= 1'b1;
        end
        if (rd_cmd && addr_ok && empty) begin
          underflow_reg <= 1'b1;
        end
        if (cmd_bad) begin
          cmd_err_reg <= 1'b1;
        end
      end
    end
  end

  assign rd_data   = rd_data_reg;
  assign rd_valid  = rd_valid_reg;
  assign level     = level_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
  assign addr_err  = addr_err_reg;
  assign cmd_err   = cmd_err_reg;

`ifdef ADC_BUF_CHECKSUM_EN
  logic [15:0] checksum_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum_reg <= '0;
    end else if (fifo_init) begin
      checksum_reg <= '0;
    end else if (wr_accept && (sdram_byte_sel == 2'b11)) begin
      checksum_reg <= checksum_reg + sdram_data;
    end
  end

  assign checksum = checksum_reg;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_adc_sample_buffer_slave.sv
// Randomised self-checking bench for adc_sample_buffer_slave against a command-level reference model.
module tb_adc_sample_buffer_slave;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fifo_init, fifo_write, fifo_read, sdram_op_rw;
  logic [1:0]  sdram_byte_sel;
  logic [31:0] sdram_addr;
  logic [15:0] sdram_data;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [7:0]  level;
  logic        full, empty, overflow, underflow, addr_err, cmd_err;
  logic [15:0] checksum;

  adc_sample_buffer_slave dut (
    .clk(clk), .reset_n(reset_n), .fifo_init(fifo_init), .fifo_write(fifo_write),
    .fifo_read(fifo_read), .sdram_op_rw(sdram_op_rw), .sdram_byte_sel(sdram_byte_sel),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .level(level), .full(full), .empty(empty), .overflow(overflow), .underflow(underflow),
    .addr_err(addr_err), .cmd_err(cmd_err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Reference model state: what the outputs must be after the latest clock edge.
  logic [15:0] m_mem [128];
  int          m_level;
  logic        m_rd_valid;
  logic [15:0] m_rd_data;
  logic        m_ovf, m_unf, m_aerr, m_cerr;
  logic [15:0] m_sum;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    m_level = 0; m_rd_valid = 0; m_ovf = 0; m_unf = 0; m_aerr = 0; m_cerr = 0; m_sum = 0;
  endtask

  task automatic model_update();
    if (fifo_init) begin
      model_clear();
    end else if (fifo_write && fifo_read) begin
      m_cerr = 1; m_rd_valid = 0;
    end else if (fifo_write && sdram_op_rw) begin
      m_rd_valid = 0;
      if (sdram_addr >= 128) m_aerr = 1;
      else if (m_level == 128) m_ovf = 1;
      else begin
        if (sdram_byte_sel[0]) m_mem[sdram_addr[6:0]][7:0]  = sdram_data[7:0];
        if (sdram_byte_sel[1]) m_mem[sdram_addr[6:0]][15:8] = sdram_data[15:8];
        m_level++;
`ifdef ADC_BUF_CHECKSUM_EN
        if (sdram_byte_sel == 2'b11) m_sum = m_sum + sdram_data;
`endif
      end
    end else if (fifo_read && !sdram_op_rw) begin
      m_rd_valid = 1;
      if (sdram_addr >= 128) begin
        m_aerr = 1; m_rd_data = 16'h0000;
      end else begin
        m_rd_data = m_mem[sdram_addr[6:0]];
        if (m_level == 0) m_unf = 1;
        else m_level--;
      end
    end else if (fifo_write || fifo_read) begin
      m_cerr = 1; m_rd_valid = 0;
    end else begin
      m_rd_valid = 0;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      if (m_rd_valid) chk("rd_data", 32'(rd_data), 32'(m_rd_data));
      chk("level", 32'(level), 32'(m_level));
      chk("full", 32'(full), 32'(m_level == 128));
      chk("empty", 32'(empty), 32'(m_level == 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
      chk("addr_err", 32'(addr_err), 32'(m_aerr));
      chk("cmd_err", 32'(cmd_err), 32'(m_cerr));
      chk("checksum", 32'(checksum), 32'(m_sum));
    end
  end

  task automatic step(input bit i, input bit w, input bit r, input bit op,
                      input logic [1:0] bs, input logic [31:0] a, input logic [15:0] d);
    @(negedge clk);
    fifo_init = i; fifo_write = w; fifo_read = r; sdram_op_rw = op;
    sdram_byte_sel = bs; sdram_addr = a; sdram_data = d;
    n_txn++;
    $display("txn %0d: init=%0b wr=%0b rd=%0b op=%0b bs=%b addr=%0h data=%h", n_txn, i, w, r, op, bs, a, d);
    @(posedge clk);
    model_update();
  endtask

  task automatic wr(input logic [31:0] a, input logic [15:0] d, input logic [1:0] bs);
    step(0, 1, 0, 1, bs, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    step(0, 0, 1, 0, 2'b00, a, 16'h0000);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 2'b00, 32'h0, 16'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'h0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
    chk({tag, "_level"}, 32'(level), 32'h0);
    chk({tag, "_empty"}, 32'(empty), 32'h1);
    chk({tag, "_full"}, 32'(full), 32'h0);
    chk({tag, "_flags"}, {28'h0, overflow, underflow, addr_err, cmd_err}, 32'h0);
    chk({tag, "_checksum"}, 32'(checksum), 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    fifo_init = 0; fifo_write = 0; fifo_read = 0; sdram_op_rw = 0;
    sdram_byte_sel = 0; sdram_addr = 0; sdram_data = 0;
    for (int k = 0; k < 128; k++) m_mem[k] = 16'h0000;
    model_clear();
    m_rd_data = 16'h0000;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cmp_en = 1;

    // Fill the buffer with addr*3.
    step(1, 0, 0, 0, 2'b00, 32'h0, 16'h0);
    for (int k = 0; k < 128; k++) wr(k, 16'(k * 3), 2'b11);
    #1;
    chk("fill_level", 32'(level), 32'd128);
    chk("fill_full", 32'(full), 32'h1);
    chk("model_fill_level", 32'(m_level), 32'd128);

    // Drain back-to-back.
    for (int k = 0; k < 128; k++) begin
      rd(k);
      if (k == 5) begin
        #1;
        chk("read5_data", 32'(rd_data), 32'd15);
        chk("read5_valid", 32'(rd_valid), 32'h1);
      end
    end
    #1;
    chk("drain_last_data", 32'(rd_data), 32'd381);
    chk("drain_empty", 32'(empty), 32'h1);

    // Refill, then overflow at addr 5 must leave mem[5] intact.
    for (int k = 0; k < 128; k++) wr(k, 16'(k * 3), 2'b11);
    wr(5, 16'hFFFF, 2'b11);
    #1;
    chk("overflow_set", 32'(overflow), 32'h1);
    rd(5);
    #1;
    chk("overflow_mem5", 32'(rd_data), 32'd15);
    step(1, 0, 0, 0, 2'b00, 32'h0, 16'h0);
    #1;
    chk("init_overflow", 32'(overflow), 32'h0);
    chk("init_level", 32'(level), 32'h0);

    // Address and command errors.
    wr(200, 16'h5555, 2'b11);
    #1;
    chk("addr_err_wr", 32'(addr_err), 32'h1);
    chk("addr_err_level", 32'(level), 32'h0);
    rd(200);
    #1;
    chk("addr_err_rd_valid", 32'(rd_valid), 32'h1);
    chk("addr_err_rd_data", 32'(rd_data), 32'h0);
    step(0, 1, 0, 0, 2'b11, 32'd3, 16'h7777);
    step(0, 1, 1, 1, 2'b11, 32'd3, 16'h7777);
    #1;
    chk("cmd_err_set", 32'(cmd_err), 32'h1);
    chk("cmd_err_level", 32'(level), 32'h0);

    // Byte-lane merge, read on the very next cycle.
    step(1, 0, 0, 0, 2'b00, 32'h0, 16'h0);
    wr(10, 16'h1234, 2'b11);
    wr(10, 16'hABCD, 2'b01);
    rd(10);
    #1;
    chk("byte_merge", 32'(rd_data), 32'h12CD);

    // Checksum of 1, 2, 3.
    step(1, 0, 0, 0, 2'b00, 32'h0, 16'h0);
    wr(0, 16'd1, 2'b11);
    wr(1, 16'd2, 2'b11);
    wr(2, 16'd3, 2'b11);
    #1;
`ifdef ADC_BUF_CHECKSUM_EN
    chk("checksum_123", 32'(checksum), 32'd6);
`else
    chk("checksum_off", 32'(checksum), 32'd0);
`endif

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      int sel;
      logic [31:0] a;
      sel = int'($urandom_range(0, 99));
      a = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 127));
      if (sel < 2)       step(1, 0, 0, 0, 2'b00, a, 16'($urandom()));
      else if (sel < 48) wr(a, 16'($urandom()), 2'($urandom()));
      else if (sel < 92) rd(a);
      else if (sel < 96) step(0, 1'($urandom()), 1'($urandom()), 1'($urandom()), 2'($urandom()), a, 16'($urandom()));
      else               idle();
    end

    // Asynchronous reset in the middle of a write burst.
    for (int k = 0; k < 6; k++) wr(k + 20, 16'(k + 100), 2'b11);
    #2;
    cmp_en = 0;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_clear();
    fifo_write = 0; sdram_op_rw = 0;
    @(negedge clk);
    reset_n = 1'b1;
    cmp_en = 1;
    step(1, 0, 0, 0, 2'b00, 32'h0, 16'h0);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) wr($urandom_range(0, 127), 16'($urandom()), 2'b11);
      else rd($urandom_range(0, 127));
    end
    idle();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
